// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus between the load-store path and data_memory_ctrl
interface data_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_byte_en;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_error;
  logic                    init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byte_en,
    input  req_ready, rsp_valid, rsp_data, rsp_error, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byte_en,
    output req_ready, rsp_valid, rsp_data, rsp_error, init_done
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-enable data RAM with latency pipeline and range check
// Optional post-reset zero sweep enabled by DMEM_INIT_CLEAR_EN.
module data_memory_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input logic               clock,
  input logic               reset,
  data_memory_ctrl_if.slave bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  init_done_q, init_done_d;
  logic                  accept;
  logic                  in_range;
  logic [IDX_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [BE_W-1:0]       mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  pipe_valid_q [READ_LATENCY];
  logic                  pipe_valid_d [READ_LATENCY];
  logic                  pipe_err_q   [READ_LATENCY];
  logic                  pipe_err_d   [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_d  [READ_LATENCY];

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] clear_addr_q, clear_addr_d;

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    init_done_d  = init_done_q;
    case (state_q)
      ST_CLEAR: begin
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == IDX_W'(DEPTH - 1)) begin
          state_d      = ST_RUN;
          clear_addr_d = '0;
          init_done_d  = 1'b1;
        end
      end
      ST_RUN: init_done_d = 1'b1;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end
`else
  always_comb begin
    init_done_d = 1'b1;
  end
`endif

  // Outputs are forced low combinationally so they read zero during the whole reset window.
  assign bus.req_ready = init_done_q & ~reset;
  assign bus.init_done = init_done_q & ~reset;
  assign bus.rsp_valid = pipe_valid_q[READ_LATENCY-1] & ~reset;
  assign bus.rsp_error = pipe_err_q[READ_LATENCY-1] & ~reset;
  assign bus.rsp_data  = reset ? '0 : pipe_data_q[READ_LATENCY-1];

  always_comb begin
    accept   = bus.req_valid & bus.req_ready;
    in_range = {1'b0, bus.req_addr} < DEPTH_EXT;
    req_idx  = bus.req_addr[IDX_W-1:0];
    rd_data  = '0;
    if (accept && !bus.req_write && in_range) begin
      rd_data = mem_q[req_idx];
    end
  end

  always_comb begin
    mem_we    = '0;
    mem_idx   = req_idx;
    mem_wdata = bus.req_wdata;
`ifdef DMEM_INIT_CLEAR_EN
    if (state_q == ST_CLEAR && !reset) begin
      mem_we    = '1;
      mem_idx   = clear_addr_q;
      mem_wdata = '0;
    end
`endif
    if (accept && bus.req_write && in_range) begin
      mem_we = bus.req_byte_en;
    end
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < BE_W; b++) begin
      if (mem_we[b]) begin
        mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Error and data only advance with a valid beat so the last stage holds between responses.
  always_comb begin
    for (int i = 0; i < READ_LATENCY; i++) begin
      pipe_valid_d[i] = 1'b0;
      pipe_err_d[i]   = pipe_err_q[i];
      pipe_data_d[i]  = pipe_data_q[i];
    end
    pipe_valid_d[0] = accept;
    if (accept) begin
      pipe_err_d[0]  = ~in_range;
      pipe_data_d[0] = rd_data;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      if (pipe_valid_q[i-1]) begin
        pipe_err_d[i]  = pipe_err_q[i-1];
        pipe_data_d[i] = pipe_data_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      init_done_q <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_err_q[i]   <= 1'b0;
        pipe_data_q[i]  <= '0;
      end
    end else begin
      init_done_q <= init_done_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_err_q[i]   <= pipe_err_d[i];
        pipe_data_q[i]  <= pipe_data_d[i];
      end
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl (DEPTH=1000, READ_LATENCY=3)
module tb_data_memory_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;
  localparam int RL    = 3;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
        check("rsp_error", 64'(bus.rsp_error), 64'(e.err));
        check("rsp_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [3:0] be, input logic exp_err, input logic [DW-1:0] exp_data,
                      input bit track);
    exp_t e;
    @(negedge clock);
    bus.req_valid   = 1'b1;
    bus.req_write   = wr;
    bus.req_addr    = addr;
    bus.req_wdata   = wd;
    bus.req_byte_en = be;
    check("req_ready_at_send", 64'(bus.req_ready), 64'd1);
    if (track) begin
      e.err  = exp_err;
      e.data = exp_data;
      e.due  = cyc + RL;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.req_valid = 1'b0;
    end
  endtask

`ifdef DMEM_INIT_CLEAR_EN
  task automatic wait_clear(input string name);
    int k;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < DEPTH + 20) begin
      @(negedge clock);
      k++;
    end
    check(name, 64'(k), 64'(DEPTH));
    check("init_done_after_clear", 64'(bus.init_done), 64'd1);
  endtask
`endif

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_byte_en = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("reset_rsp_error", 64'(bus.rsp_error), 64'd0);
    check("reset_init_done", 64'(bus.init_done), 64'd0);
    reset = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
    wait_clear("clear_ready_delay");
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), '0, 4'h0, 1'b0, 32'h0, 1'b1);
    idle(RL + 2);
`else
    @(negedge clock);
    check("ready_after_reset", 64'(bus.req_ready), 64'd1);
    check("init_done_after_reset", 64'(bus.init_done), 64'd1);
`endif
    // Byte-enable merges
    send(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b1);
    send(1'b1, 10'd5, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1'b1);
    send(1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b1);
    send(1'b1, 10'd5, 32'h55555555, 4'h0, 1'b0, 32'h0, 1'b1);
    send(1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b1);
    send(1'b1, 10'd20, 32'h01234567, 4'hF, 1'b0, 32'h0, 1'b1);
    send(1'b1, 10'd20, 32'hFFFFFFFF, 4'b1010, 1'b0, 32'h0, 1'b1);
    send(1'b0, 10'd20, 32'h0, 4'h0, 1'b0, 32'hFF23FF67, 1'b1);
    idle(RL + 2);
    // Preload then back-to-back reads through the latency pipeline
    for (int i = 0; i < 8; i++) send(1'b1, AW'(i), DW'(i), 4'hF, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b0, AW'(i), '0, 4'h0, 1'b0, DW'(i), 1'b1);
    idle(RL + 2);
    // Range checking at the DEPTH boundary
    send(1'b1, 10'd999, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b1);
    send(1'b0, 10'd1000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    send(1'b1, 10'd1023, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b1);
    send(1'b0, 10'd1023, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    send(1'b0, 10'd999, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b1);
    idle(RL + 2);
    check("scoreboard_drained_pre_reset", 64'(sb_q.size()), 64'd0);
    // Reset with two reads in flight: their responses must never appear
    send(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    send(1'b0, 10'd1, 32'h0, 4'h0, 1'b0, 32'h1, 1'b0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1 check("inflight_reset_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < RL + 2; i++) begin
      @(negedge clock);
      #1 check("inflight_flushed", 64'(bus.rsp_valid), 64'd0);
    end
    reset = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
    wait_clear("reclear_ready_delay");
    send(1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    send(1'b0, 10'd999, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
`else
    @(negedge clock);
    check("ready_after_rereset", 64'(bus.req_ready), 64'd1);
    send(1'b0, 10'd999, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b1);
    send(1'b0, 10'd5, 32'h0, 4'h0, 1'b0, 32'h5, 1'b1);
`endif
    idle(RL + 6);
    check("scoreboard_drained_end", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
